// File: rtl/riscblade_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package riscblade_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Identifies which requester owns the access in flight
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between IF and DM plus the IF anti-starvation counter.
// DM normally wins; after STARVE_MAX consecutive DM grants with IF waiting,
// IF is forced to win the next arbitration.
module mem_arb_select #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic if_gnt_o,
  output logic dm_gnt_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          starved;

  // Combinational grant decision and next starvation count
  always_comb begin
    starved  = if_req_i && (starve_q == SW'(STARVE_MAX));
    dm_gnt_o = en_i && dm_req_i && !starved;
    if_gnt_o = en_i && if_req_i && !dm_gnt_o;
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (dm_gnt_o && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the IF and DM ports onto a single-ported memory. Each granted
// access is registered onto MEM_* for one ACCESS cycle; reads then wait for
// the memory read latency and return data with a one-cycle valid pulse.
// Out-of-range addresses never write memory, read back as zero and raise ERR.
module mem_arbiter
  import riscblade_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_WORDS  = 32768,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IF_REQ,
  input  logic [AW-1:0] IF_ADDR,
  output logic          IF_GNT,
  output logic          IF_RVALID,
  output logic [DW-1:0] IF_RDATA,
  input  logic          DM_REQ,
  input  logic          DM_WE,
  input  logic [AW-1:0] DM_ADDR,
  input  logic [DW-1:0] DM_WDATA,
  output logic          DM_GNT,
  output logic          DM_RVALID,
  output logic [DW-1:0] DM_RDATA,
  output logic          ERR,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_DATA,
  output logic          MEM_WRITE,
  input  logic [DW-1:0] MEM_OUT,
  output logic          BUSY
);

  localparam int LW = $clog2(RD_LAT + 1);

  state_e        state_q;
  logic [LW-1:0] lat_q;
  logic          port_q;
  logic          we_q;
  logic          inr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_data_q;
  logic          mem_write_q;
  logic          if_rvalid_q;
  logic          dm_rvalid_q;
  logic          err_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;

  logic          arb_en;
  logic          if_gnt;
  logic          dm_gnt;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic          sel_inr;

  // Grants are only offered in IDLE and never while reset is asserted
  assign arb_en = (state_q == IDLE) && RST;

  mem_arb_select #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .en_i     (arb_en),
    .if_req_i (IF_REQ),
    .dm_req_i (DM_REQ),
    .if_gnt_o (if_gnt),
    .dm_gnt_o (dm_gnt)
  );

  // Request mux for the winning port; IF is always a read
  always_comb begin
    sel_addr  = dm_gnt ? DM_ADDR : IF_ADDR;
    sel_wdata = dm_gnt ? DM_WDATA : '0;
    sel_we    = dm_gnt && DM_WE;
    sel_inr   = ({1'b0, sel_addr} < (AW+1)'(MEM_WORDS));
  end

  // Access sequencer: latch on grant, drive memory for one cycle, collect read data
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      port_q      <= PORT_IF;
      we_q        <= 1'b0;
      inr_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      mem_write_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_gnt || dm_gnt) begin
            mem_addr_q  <= sel_addr;
            mem_data_q  <= sel_wdata;
            mem_write_q <= sel_we && sel_inr;
            we_q        <= sel_we;
            inr_q       <= sel_inr;
            port_q      <= dm_gnt ? PORT_DM : PORT_IF;
            // A rejected write reports its error during its ACCESS cycle
            err_q       <= sel_we && !sel_inr;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q <= IDLE;
          end else if (RD_LAT == 1) begin
            state_q <= RESP;
          end else begin
            lat_q   <= LW'(1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q == LW'(RD_LAT - 1)) begin
            state_q <= RESP;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        RESP: begin
          if (port_q == PORT_DM) begin
            dm_rdata_q  <= inr_q ? MEM_OUT : '0;
            dm_rvalid_q <= 1'b1;
          end else begin
            if_rdata_q  <= inr_q ? MEM_OUT : '0;
            if_rvalid_q <= 1'b1;
          end
          err_q   <= !inr_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IF_GNT    = if_gnt;
  assign DM_GNT    = dm_gnt;
  assign IF_RVALID = if_rvalid_q;
  assign IF_RDATA  = if_rdata_q;
  assign DM_RVALID = dm_rvalid_q;
  assign DM_RDATA  = dm_rdata_q;
  assign ERR       = err_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_DATA  = mem_data_q;
  assign MEM_WRITE = mem_write_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each attached to a small behavioural memory. Unwritten words read back as
// (address ^ 16'hA5A5).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, dm_gnt, if_rvalid, dm_rvalid, err, mem_write, busy;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_data, mem_out;

  logic        if_req3;
  logic [15:0] if_addr3;
  logic        if_gnt3, dm_gnt3, if_rvalid3, dm_rvalid3, err3, mem_write3, busy3;
  logic [15:0] if_rdata3, dm_rdata3, mem_addr3, mem_data3, mem_out3;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.RD_LAT(1)) u_dut (
    .CLK(clk), .RST(rst),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt),
    .IF_RVALID(if_rvalid), .IF_RDATA(if_rdata),
    .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata),
    .DM_GNT(dm_gnt), .DM_RVALID(dm_rvalid), .DM_RDATA(dm_rdata),
    .ERR(err), .MEM_ADDR(mem_addr), .MEM_DATA(mem_data),
    .MEM_WRITE(mem_write), .MEM_OUT(mem_out), .BUSY(busy)
  );

  mem_arbiter #(.RD_LAT(3)) u_dut3 (
    .CLK(clk), .RST(rst),
    .IF_REQ(if_req3), .IF_ADDR(if_addr3), .IF_GNT(if_gnt3),
    .IF_RVALID(if_rvalid3), .IF_RDATA(if_rdata3),
    .DM_REQ(1'b0), .DM_WE(1'b0), .DM_ADDR(16'h0000), .DM_WDATA(16'h0000),
    .DM_GNT(dm_gnt3), .DM_RVALID(dm_rvalid3), .DM_RDATA(dm_rdata3),
    .ERR(err3), .MEM_ADDR(mem_addr3), .MEM_DATA(mem_data3),
    .MEM_WRITE(mem_write3), .MEM_OUT(mem_out3), .BUSY(busy3)
  );

  // Behavioural memories
  logic [15:0] mem1 [0:32767];
  bit          wv1  [0:32767];
  bit   [14:0] ap1;
  always @(posedge clk) begin
    if (mem_write) begin
      mem1[mem_addr[14:0]] <= mem_data;
      wv1[mem_addr[14:0]]  <= 1'b1;
    end
    ap1 <= mem_addr[14:0];
  end
  assign mem_out = wv1[ap1] ? mem1[ap1] : ({1'b0, ap1} ^ 16'hA5A5);

  bit   [14:0] ap3 [0:2];
  always @(posedge clk) begin
    ap3[0] <= mem_addr3[14:0];
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign mem_out3 = {1'b0, ap3[2]} ^ 16'hA5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
    if_addr = 16'h0001; dm_addr = 16'h0002; dm_wdata = 16'h1234;
    nxt(); nxt(); #1;
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL rst_if_gnt got=%b want=0", if_gnt); end
    total++; if (dm_gnt !== 1'b0) begin bad++; $display("FAIL rst_dm_gnt got=%b want=0", dm_gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_write got=%b want=0", mem_write); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_mem_addr got=%h want=0000", mem_addr); end
    total++; if (mem_data !== 16'h0000) begin bad++; $display("FAIL rst_mem_data got=%h want=0000", mem_data); end
    total++; if ({if_rvalid, dm_rvalid, err} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b want=000", {if_rvalid, dm_rvalid, err}); end
    total++; if (if_rdata !== 16'h0000) begin bad++; $display("FAIL rst_if_rdata got=%h want=0000", if_rdata); end
    total++; if (dm_rdata !== 16'h0000) begin bad++; $display("FAIL rst_dm_rdata got=%h want=0000", dm_rdata); end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
  endtask

  task automatic test_dm_write();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
    #1;
    total++; if (dm_gnt !== 1'b1) begin bad++; $display("FAIL wr_dm_gnt got=%b want=1", dm_gnt); end
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL wr_if_gnt got=%b want=0", if_gnt); end
    nxt();
    dm_req = 1'b0; dm_we = 1'b0;
    #1;
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL wr_mem_write_on got=%b want=1", mem_write); end
    total++; if (mem_addr !== 16'h0010) begin bad++; $display("FAIL wr_mem_addr got=%h want=0010", mem_addr); end
    total++; if (mem_data !== 16'hBEEF) begin bad++; $display("FAIL wr_mem_data got=%h want=beef", mem_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b want=1", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err); end
    nxt(); #1;
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL wr_mem_write_off got=%b want=0", mem_write); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_idle got=%b want=0", busy); end
  endtask

  task automatic test_dm_read();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0010;
    #1;
    total++; if (dm_gnt !== 1'b1) begin bad++; $display("FAIL rd_dm_gnt got=%b want=1", dm_gnt); end
    nxt();
    dm_req = 1'b0;
    #1;
    total++; if (dm_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_c1 got=%b want=0", dm_rvalid); end
    nxt(); #1;
    total++; if (dm_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_c2 got=%b want=0", dm_rvalid); end
    nxt(); #1;
    total++; if (dm_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid_c3 got=%b want=1", dm_rvalid); end
    total++; if (dm_rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_dm_rdata got=%h want=beef", dm_rdata); end
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL rd_if_rvalid got=%b want=0", if_rvalid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", err); end
    nxt(); #1;
    total++; if (dm_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_c4 got=%b want=0", dm_rvalid); end
    total++; if (dm_rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_rdata_hold got=%h want=beef", dm_rdata); end
  endtask

  task automatic test_starvation();
    bit exp_dm [0:9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int ngr = 0;
    bit chk_zero = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1111;
    if_req = 1'b1; if_addr = 16'h0010;
    for (int c = 0; c < 40 && ngr < 10; c++) begin
      #1;
      if (chk_zero) begin
        chk_zero = 1'b0;
        total++; if (u_dut.u_sel.starve_q !== 3'd0) begin bad++; $display("FAIL stv_cnt_clear got=%0d want=0", u_dut.u_sel.starve_q); end
      end
      if (dm_gnt || if_gnt) begin
        total++; if ((dm_gnt && if_gnt) || dm_gnt !== exp_dm[ngr]) begin
          bad++; $display("FAIL stv_grant%0d got dm=%b if=%b want dm=%b", ngr, dm_gnt, if_gnt, exp_dm[ngr]);
        end
        if (ngr == 4) begin
          total++; if (u_dut.u_sel.starve_q !== 3'd4) begin bad++; $display("FAIL stv_cnt_sat got=%0d want=4", u_dut.u_sel.starve_q); end
          chk_zero = 1'b1;
        end
        ngr++;
      end
      nxt();
    end
    total++; if (ngr != 10) begin bad++; $display("FAIL stv_timeout got=%0d grants want=10", ngr); end
    dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b0;
    nxt(); nxt(); nxt(); nxt();
  endtask

  task automatic test_out_of_range();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'd40000; dm_wdata = 16'h5555;
    #1;
    total++; if (dm_gnt !== 1'b1) begin bad++; $display("FAIL oor_wr_gnt got=%b want=1", dm_gnt); end
    nxt();
    dm_req = 1'b0; dm_we = 1'b0;
    #1;
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL oor_wr_mem_write got=%b want=0", mem_write); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b want=1", err); end
    nxt(); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL oor_wr_err_end got=%b want=0", err); end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'd40000;
    #1;
    total++; if (dm_gnt !== 1'b1) begin bad++; $display("FAIL oor_rd_gnt got=%b want=1", dm_gnt); end
    nxt();
    dm_req = 1'b0;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL oor_rd_err_early got=%b want=0", err); end
    nxt(); nxt(); #1;
    total++; if (dm_rvalid !== 1'b1) begin bad++; $display("FAIL oor_rd_rvalid got=%b want=1", dm_rvalid); end
    total++; if (dm_rdata !== 16'h0000) begin bad++; $display("FAIL oor_rd_rdata got=%h want=0000", dm_rdata); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b want=1", err); end
    nxt(); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL oor_rd_err_end got=%b want=0", err); end
  endtask

  task automatic test_reset_inflight();
    if_req = 1'b1; if_addr = 16'h0100;
    #1;
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rif_gnt got=%b want=1", if_gnt); end
    nxt();
    if_req = 1'b0;
    nxt();
    rst = 1'b0;
    nxt();
    if_req = 1'b1;
    #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL rif_no_rvalid got=%b want=0", if_rvalid); end
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL rif_gnt_in_rst got=%b want=0", if_gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rif_busy got=%b want=0", busy); end
    total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL rif_mem_addr got=%h want=0000", mem_addr); end
    total++; if (if_rdata !== 16'h0000) begin bad++; $display("FAIL rif_if_rdata got=%h want=0000", if_rdata); end
    total++; if ({mem_write, err, dm_rvalid} !== 3'b000) begin bad++; $display("FAIL rif_ctl got=%b want=000", {mem_write, err, dm_rvalid}); end
    nxt();
    rst = 1'b1;
    #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL rif_dropped got=%b want=0", if_rvalid); end
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rif_regnt got=%b want=1", if_gnt); end
    nxt();
    if_req = 1'b0;
    nxt(); nxt(); #1;
    total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL rif_rvalid got=%b want=1", if_rvalid); end
    total++; if (if_rdata !== 16'hA4A5) begin bad++; $display("FAIL rif_rdata got=%h want=a4a5", if_rdata); end
    nxt(); #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL rif_rvalid_end got=%b want=0", if_rvalid); end
  endtask

  task automatic test_rd_lat3();
    if_req3 = 1'b1; if_addr3 = 16'h0200;
    #1;
    total++; if (if_gnt3 !== 1'b1) begin bad++; $display("FAIL l3_gnt got=%b want=1", if_gnt3); end
    for (int k = 1; k <= 4; k++) begin
      nxt(); #1;
      total++; if ({if_gnt3, if_rvalid3, busy3} !== 3'b001) begin
        bad++; $display("FAIL l3_busy_c%0d got gnt/rvalid/busy=%b want=001", k, {if_gnt3, if_rvalid3, busy3});
      end
    end
    nxt(); #1;
    total++; if (if_rvalid3 !== 1'b1) begin bad++; $display("FAIL l3_rvalid got=%b want=1", if_rvalid3); end
    total++; if (if_rdata3 !== 16'hA7A5) begin bad++; $display("FAIL l3_rdata got=%h want=a7a5", if_rdata3); end
    total++; if (if_gnt3 !== 1'b1) begin bad++; $display("FAIL l3_regnt got=%b want=1", if_gnt3); end
    nxt();
    if_req3 = 1'b0;
    for (int k = 0; k < 6; k++) nxt();
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0;
    nxt();
    test_reset();
    test_dm_write();
    test_dm_read();
    test_starvation();
    test_out_of_range();
    test_reset_inflight();
    test_rd_lat3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
